bin2bcd_seq: RTL and testbench

Multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, with a start/done handshake. It sits between the adder stage and the seven-segment controller. It takes the 8-bit adder result, which is unsigned or two's-complement depending on add/subtract mode. It produces a held, stable 3-digit BCD magnitude plus a sign flag for the display stage.

---
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 97 +++++++++
 tb/tb_bin2bcd_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the adder stage, the BCD converter
// and the seven-segment controller.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;

  modport master (
    output start, bin, signed_mode,
    input  busy, done, bcd, neg
  );

  modport slave (
    input  start, bin, signed_mode,
    output busy, done, bcd, neg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with a start/done
// handshake; bcd/neg are held between completions so the display never flickers.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  shift_reg;
  logic [BW-1:0]     bcd_work;
  logic [CW-1:0]     count;
  logic              sign;

  logic [WIDTH-1:0]  neg_mag;
  logic              take_neg;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_shifted;
  logic              last_iter;

  // Two's-complement magnitude; 0x80 wraps to itself and reads as 128.
  assign neg_mag  = ~bus.bin + WIDTH'(1);
  assign take_neg = bus.signed_mode & bus.bin[WIDTH-1];

  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_work[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
    end
  end

  assign bcd_shifted = {bcd_adj[BW-2:0], shift_reg[WIDTH-1]};
  assign last_iter   = (state == SHIFT) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The last iteration writes the shifted value straight to the held output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_work  <= '0;
      count     <= '0;
      sign      <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.bcd   <= '0;
      bus.neg   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg <= take_neg ? neg_mag : bus.bin;
            sign      <= take_neg;
            bcd_work  <= '0;
            count     <= '0;
            bus.busy  <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_work  <= bcd_shifted;
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          count     <= count + CW'(1);
          if (last_iter) begin
            bus.bcd  <= bcd_shifted;
            bus.neg  <= sign;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: handshake timing, held outputs, signed
// cases, ignored/back-to-back starts, mid-run reset and a full sweep.
module tb_bin2bcd_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: {neg, hundreds, tens, ones} by division.
  function automatic logic [12:0] refModel(input logic [7:0] b, input logic s);
    int   m;
    logic ng;
    ng = s & b[7];
    m  = ng ? 256 - int'(b) : int'(b);
    return {ng, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Issues one conversion from IDLE and waits for done. lat counts edges from
  // the accepting edge to the edge that first samples done high.
  task automatic applyStimulus(input logic [7:0] b, input logic s,
                               output logic [11:0] r_bcd, output logic r_neg,
                               output int lat, output int busy_cnt);
    logic [11:0] prev_bcd;
    logic        prev_neg;
    logic        hold_ok;
    int          n;
    prev_bcd = bus.bcd;
    prev_neg = bus.neg;
    hold_ok  = 1'b1;
    bus.bin = b;
    bus.signed_mode = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin = ~b;
    bus.signed_mode = ~s;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 30) begin
      if (bus.busy) busy_cnt++;
      if (bus.bcd !== prev_bcd || bus.neg !== prev_neg) hold_ok = 1'b0;
      tick();
      n++;
    end
    lat   = n + 1;
    r_bcd = bus.bcd;
    r_neg = bus.neg;
    checkOutput("hold_during_conv", 32'(hold_ok), 32'd1);
    tick();
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  logic [11:0] r_bcd;
  logic        r_neg;
  logic [12:0] exp_v;
  int          lat, busy_cnt, n;
  logic        saw_done;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin = '0;
    bus.signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_bcd", 32'(bus.bcd), 32'h000);
    checkOutput("reset_neg", 32'(bus.neg), 32'd0);
    tick();

    $display("[TB] zero and full-scale unsigned");
    applyStimulus(8'd0, 1'b0, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("zero_bcd", 32'(r_bcd), 32'h000);
    checkOutput("zero_neg", 32'(r_neg), 32'd0);
    checkOutput("zero_latency", 32'(lat), 32'd9);
    checkOutput("zero_busy_cycles", 32'(busy_cnt), 32'd8);
    applyStimulus(8'd255, 1'b0, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("u255_bcd", 32'(r_bcd), 32'h255);
    checkOutput("u255_neg", 32'(r_neg), 32'd0);

    $display("[TB] signed cases");
    applyStimulus(8'hFB, 1'b1, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("sFB_bcd", 32'(r_bcd), 32'h005);
    checkOutput("sFB_neg", 32'(r_neg), 32'd1);
    applyStimulus(8'h80, 1'b1, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("s80_bcd", 32'(r_bcd), 32'h128);
    checkOutput("s80_neg", 32'(r_neg), 32'd1);
    applyStimulus(8'h80, 1'b0, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("u80_bcd", 32'(r_bcd), 32'h128);
    checkOutput("u80_neg", 32'(r_neg), 32'd0);
    applyStimulus(8'h00, 1'b1, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("s00_neg", 32'(r_neg), 32'd0);

    $display("[TB] start while busy, then held start");
    bus.bin = 8'd99;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin = 8'd7;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("b2b_first_done", 32'(bus.done), 32'd1);
    checkOutput("b2b_first_bcd", 32'(bus.bcd), 32'h099);
    checkOutput("b2b_not_busy", 32'(bus.busy), 32'd0);
    bus.bin = 8'd42;
    bus.start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      tick();
      n++;
      while (!bus.done && n < 30) begin
        tick();
        n++;
      end
      checkOutput("b2b_spacing", 32'(n), 32'd9);
      checkOutput("b2b_bcd", 32'(bus.bcd), 32'h042);
    end
    bus.start = 1'b0;
    tick();
    tick();

    $display("[TB] reset mid-conversion");
    bus.bin = 8'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    checkOutput("abort_prev_bcd", 32'(bus.bcd), 32'h042);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_bcd", 32'(bus.bcd), 32'h000);
    checkOutput("abort_neg", 32'(bus.neg), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);
    applyStimulus(8'd13, 1'b0, r_bcd, r_neg, lat, busy_cnt);
    checkOutput("after_abort_bcd", 32'(r_bcd), 32'h013);
    checkOutput("after_abort_latency", 32'(lat), 32'd9);

    $display("[TB] exhaustive sweep");
    for (int sm = 0; sm < 2; sm++) begin
      for (int v = 0; v < 256; v++) begin
        exp_v = refModel(8'(v), 1'(sm));
        applyStimulus(8'(v), 1'(sm), r_bcd, r_neg, lat, busy_cnt);
        checkOutput("sweep_bcd", 32'(r_bcd), 32'(exp_v[11:0]));
        checkOutput("sweep_neg", 32'(r_neg), 32'(exp_v[12]));
        checkOutput("sweep_latency", 32'(lat), 32'd9);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
